ad9361_dual_tx_axis: RTL and testbench

- Transmit-direction counterpart of the dual receive AXI-stream serializer.
- Accepts 128-bit AXI-stream beats and buffers them in a small FIFO. Each beat carries one I/Q sample for each of 4 channels: A0, A1, B0, B1.
- Unpacks one beat per sample request from the transmit CMOS interface and presents per-channel strobed 12-bit I/Q.
- Sits between the DMA/AXIS fabric and the two AD9361 transmit CMOS interfaces, in the data clock domain.

---
 rtl/ad9361_pkg.sv | 26 ++
 rtl/ad9361_tx_fifo.sv | 52 +++++
 rtl/ad9361_dual_tx_axis.sv | 131 +++++++++++++
 tb/tb_ad9361_dual_tx_axis.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ad9361_pkg.sv
// Shared constants and types for the AD9361 dual transmit AXI-stream unpacker.
package ad9361_pkg;
  localparam int NUM_CHANNELS = 4;
  localparam int SAMPLE_WIDTH = 12;
  localparam int LANE_WIDTH   = 16;
  localparam int AXIS_WIDTH   = 128;
  localparam int NUM_LANES    = AXIS_WIDTH / LANE_WIDTH;

  localparam int LANE_I0 = 0, LANE_Q0 = 1;
  localparam int LANE_I1 = 2, LANE_Q1 = 3;
  localparam int LANE_I2 = 4, LANE_Q2 = 5;
  localparam int LANE_I3 = 6, LANE_Q3 = 7;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] i;
    logic [SAMPLE_WIDTH-1:0] q;
  } iq_t;

  function automatic int lane_i(input int ch);
    return LANE_I0 + 2 * ch;
  endfunction

  function automatic int lane_q(input int ch);
    return LANE_Q0 + 2 * ch;
  endfunction
endpackage

// File: rtl/ad9361_tx_fifo.sv
// Small synchronous beat FIFO; full/empty come from the level counter, pointers wrap.
module ad9361_tx_fifo #(
  parameter int LOG2_DEPTH = 2,
  parameter int WIDTH      = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [LOG2_DEPTH:0]   level
);
  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign full    = (level == (LOG2_DEPTH+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (LOG2_DEPTH+1)'(1);
        2'b01:   level <= level - (LOG2_DEPTH+1)'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/ad9361_dual_tx_axis.sv
// AXIS beat FIFO -> per-request unpack into four strobed 12-bit I/Q channels,
// with underflow fill (zeros or last sample) and a sticky saturating underflow counter.
module ad9361_dual_tx_axis
  import ad9361_pkg::*;
#(
  parameter int LOG2_DEPTH     = 2,
  parameter bit REVERSE_DATA   = 1'b0,
  parameter bit UNDERFLOW_MODE = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tx_enable,
  input  logic                    sample_req,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [AXIS_WIDTH-1:0]   s_axis_tdata,
  output logic                    valid_0,
  output logic                    valid_1,
  output logic                    valid_2,
  output logic                    valid_3,
  output logic [SAMPLE_WIDTH-1:0] data_i0,
  output logic [SAMPLE_WIDTH-1:0] data_q0,
  output logic [SAMPLE_WIDTH-1:0] data_i1,
  output logic [SAMPLE_WIDTH-1:0] data_q1,
  output logic [SAMPLE_WIDTH-1:0] data_i2,
  output logic [SAMPLE_WIDTH-1:0] data_q2,
  output logic [SAMPLE_WIDTH-1:0] data_i3,
  output logic [SAMPLE_WIDTH-1:0] data_q3,
  output logic                    underflow,
  input  logic                    underflow_clear,
  output logic [15:0]             underflow_count,
  output logic [LOG2_DEPTH:0]     fifo_level
);
  logic                  run;
  logic                  full, empty;
  logic                  req, do_push, do_pop, uf_evt;
  logic [AXIS_WIDTH-1:0] head;
  logic                  vld_q;
  iq_t [NUM_CHANNELS-1:0] head_iq, out_iq, last_iq;
  logic [NUM_LANES*(LANE_WIDTH-SAMPLE_WIDTH)-1:0] unused_nibbles;

  // Ready stays low until the first clock after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run <= 1'b0;
    else     run <= 1'b1;
  end

  assign s_axis_tready = run && tx_enable && !full;
  assign do_push       = s_axis_tvalid && s_axis_tready;
  assign req           = tx_enable && sample_req;
  assign do_pop        = req && !empty;
  assign uf_evt        = req && empty;

  ad9361_tx_fifo #(
    .LOG2_DEPTH (LOG2_DEPTH),
    .WIDTH      (AXIS_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (do_push),
    .pop     (do_pop),
    .flush   (!tx_enable),
    .wr_data (s_axis_tdata),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // Reversal swaps whole channels; I/Q order within a channel is kept.
  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_unpack
    localparam int SRC = REVERSE_DATA ? (NUM_CHANNELS - 1 - ch) : ch;
    localparam int LI  = lane_i(SRC) * LANE_WIDTH;
    localparam int LQ  = lane_q(SRC) * LANE_WIDTH;
    assign head_iq[ch].i = head[LI +: SAMPLE_WIDTH];
    assign head_iq[ch].q = head[LQ +: SAMPLE_WIDTH];
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_nib
    assign unused_nibbles[k*(LANE_WIDTH-SAMPLE_WIDTH) +: (LANE_WIDTH-SAMPLE_WIDTH)] =
      head[k*LANE_WIDTH+SAMPLE_WIDTH +: (LANE_WIDTH-SAMPLE_WIDTH)];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      out_iq  <= '0;
      last_iq <= '0;
    end else if (!tx_enable) begin
      vld_q   <= 1'b0;
      out_iq  <= '0;
      last_iq <= '0;
    end else begin
      vld_q <= req;
      if (do_pop) begin
        out_iq  <= head_iq;
        last_iq <= head_iq;
      end else if (uf_evt) begin
        out_iq  <= UNDERFLOW_MODE ? last_iq : '0;
      end
    end
  end

  // A same-cycle event beats the clear: flag stays set and the count restarts at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else if (uf_evt) begin
      underflow <= 1'b1;
      if (underflow_clear)                underflow_count <= 16'd1;
      else if (underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
    end else if (underflow_clear) begin
      underflow       <= 1'b0;
      underflow_count <= '0;
    end
  end

  assign valid_0 = vld_q;
  assign valid_1 = vld_q;
  assign valid_2 = vld_q;
  assign valid_3 = vld_q;
  assign data_i0 = out_iq[0].i;
  assign data_q0 = out_iq[0].q;
  assign data_i1 = out_iq[1].i;
  assign data_q1 = out_iq[1].q;
  assign data_i2 = out_iq[2].i;
  assign data_q2 = out_iq[2].q;
  assign data_i3 = out_iq[3].i;
  assign data_q3 = out_iq[3].q;
endmodule

// File: tb/tb_ad9361_dual_tx_axis.sv
// Directed bench: instance a (normal, zero-fill) and instance b (reversed, repeat-last) share stimulus.
module tb_ad9361_dual_tx_axis;
  logic         clk = 1'b0, rst = 1'b1, tx_enable = 1'b0, sample_req = 1'b0;
  logic         s_axis_tvalid = 1'b0, underflow_clear = 1'b0;
  logic [127:0] s_axis_tdata = '0;

  logic        a_rdy, a_v0, a_v1, a_v2, a_v3, a_uf;
  logic [11:0] a_i0, a_q0, a_i1, a_q1, a_i2, a_q2, a_i3, a_q3;
  logic [15:0] a_cnt;
  logic [2:0]  a_lvl;
  logic        b_rdy, b_v0, b_v1, b_v2, b_v3, b_uf;
  logic [11:0] b_i0, b_q0, b_i1, b_q1, b_i2, b_q2, b_i3, b_q3;
  logic [15:0] b_cnt;
  logic [2:0]  b_lvl;

  ad9361_dual_tx_axis #(.LOG2_DEPTH(2), .REVERSE_DATA(1'b0), .UNDERFLOW_MODE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .sample_req(sample_req),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(a_rdy), .s_axis_tdata(s_axis_tdata),
    .valid_0(a_v0), .valid_1(a_v1), .valid_2(a_v2), .valid_3(a_v3),
    .data_i0(a_i0), .data_q0(a_q0), .data_i1(a_i1), .data_q1(a_q1),
    .data_i2(a_i2), .data_q2(a_q2), .data_i3(a_i3), .data_q3(a_q3),
    .underflow(a_uf), .underflow_clear(underflow_clear), .underflow_count(a_cnt),
    .fifo_level(a_lvl));

  ad9361_dual_tx_axis #(.LOG2_DEPTH(2), .REVERSE_DATA(1'b1), .UNDERFLOW_MODE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .sample_req(sample_req),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(b_rdy), .s_axis_tdata(s_axis_tdata),
    .valid_0(b_v0), .valid_1(b_v1), .valid_2(b_v2), .valid_3(b_v3),
    .data_i0(b_i0), .data_q0(b_q0), .data_i1(b_i1), .data_q1(b_q1),
    .data_i2(b_i2), .data_q2(b_q2), .data_i3(b_i3), .data_q3(b_q3),
    .underflow(b_uf), .underflow_clear(underflow_clear), .underflow_count(b_cnt),
    .fifo_level(b_lvl));

  always #5 clk = ~clk;

  logic [47:0] a_i, a_q, b_i, b_q;
  logic [3:0]  a_v, b_v;
  assign a_i = {a_i3, a_i2, a_i1, a_i0};
  assign a_q = {a_q3, a_q2, a_q1, a_q0};
  assign b_i = {b_i3, b_i2, b_i1, b_i0};
  assign b_q = {b_q3, b_q2, b_q1, b_q0};
  assign a_v = {a_v3, a_v2, a_v1, a_v0};
  assign b_v = {b_v3, b_v2, b_v1, b_v0};

  typedef struct packed {
    logic [127:0] data;
    logic [47:0]  ei, eq, ri, rq;
  } vec_t;
  vec_t vt [4];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [3:0] ev,
                         input logic [47:0] ai, aq, bi, bq);
    chk({nm, " valid_a"}, 64'(a_v), 64'(ev));
    chk({nm, " valid_b"}, 64'(b_v), 64'(ev));
    chk({nm, " i_a"}, 64'(a_i), 64'(ai));
    chk({nm, " q_a"}, 64'(a_q), 64'(aq));
    chk({nm, " i_b"}, 64'(b_i), 64'(bi));
    chk({nm, " q_b"}, 64'(b_q), 64'(bq));
  endtask

  task automatic chk_uf(input string nm, input logic f, input logic [15:0] c);
    chk({nm, " flag_a"}, 64'(a_uf), 64'(f));
    chk({nm, " flag_b"}, 64'(b_uf), 64'(f));
    chk({nm, " cnt_a"}, 64'(a_cnt), 64'(c));
    chk({nm, " cnt_b"}, 64'(b_cnt), 64'(c));
  endtask

  task automatic chk_lvl(input string nm, input logic [2:0] l, input logic r);
    chk({nm, " level_a"}, 64'(a_lvl), 64'(l));
    chk({nm, " level_b"}, 64'(b_lvl), 64'(l));
    chk({nm, " ready_a"}, 64'(a_rdy), 64'(r));
    chk({nm, " ready_b"}, 64'(b_rdy), 64'(r));
  endtask

  task automatic push(input logic [127:0] d);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    vt[0] = '{data: {16'hF777, 16'hF666, 16'hF555, 16'hF444, 16'hF333, 16'hF222, 16'hF111, 16'hF000},
              ei: {12'h666, 12'h444, 12'h222, 12'h000}, eq: {12'h777, 12'h555, 12'h333, 12'h111},
              ri: {12'h000, 12'h222, 12'h444, 12'h666}, rq: {12'h111, 12'h333, 12'h555, 12'h777}};
    vt[1] = '{data: {16'h8E0F, 16'h7C0D, 16'h6A0B, 16'h5789, 16'h4456, 16'h3123, 16'h2DEF, 16'h1ABC},
              ei: {12'hC0D, 12'h789, 12'h123, 12'hABC}, eq: {12'hE0F, 12'hA0B, 12'h456, 12'hDEF},
              ri: {12'hABC, 12'h123, 12'h789, 12'hC0D}, rq: {12'hDEF, 12'h456, 12'hA0B, 12'hE0F}};
    vt[2] = '{data: {8{16'hFFFF}},
              ei: {4{12'hFFF}}, eq: {4{12'hFFF}}, ri: {4{12'hFFF}}, rq: {4{12'hFFF}}};
    vt[3] = '{data: {16'h0807, 16'h0806, 16'h0805, 16'h0804, 16'h0803, 16'h0802, 16'h0801, 16'h0800},
              ei: {12'h806, 12'h804, 12'h802, 12'h800}, eq: {12'h807, 12'h805, 12'h803, 12'h801},
              ri: {12'h800, 12'h802, 12'h804, 12'h806}, rq: {12'h801, 12'h803, 12'h805, 12'h807}};

    // Reset state, then release
    tx_enable = 1'b1;
    repeat (3) tick();
    chk_lvl("in_reset", 3'd0, 1'b0);
    chk_out("in_reset", 4'h0, '0, '0, '0, '0);
    chk_uf("in_reset", 1'b0, 16'd0);
    rst = 1'b0;
    tick();
    chk_lvl("post_reset", 3'd0, 1'b1);

    // Reset mid-stream: 3 pushes, one pop, then async reset between edges
    push(vt[0].data);
    push(vt[1].data);
    push(vt[2].data);
    chk_lvl("three_pushes", 3'd3, 1'b1);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    chk_out("pre_reset_pop", 4'hF, vt[0].ei, vt[0].eq, vt[0].ri, vt[0].rq);
    #2 rst = 1'b1;
    #1;
    chk_lvl("async_reset", 3'd0, 1'b0);
    chk_out("async_reset", 4'h0, '0, '0, '0, '0);
    tick();
    rst = 1'b0;
    tick();
    chk_lvl("rerelease", 3'd0, 1'b1);

    // Table: push one beat, request, check strobe at t+1 and hold at t+2
    for (int k = 0; k < 4; k++) begin
      push(vt[k].data);
      sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      chk_out($sformatf("vec%0d strobe", k), 4'hF, vt[k].ei, vt[k].eq, vt[k].ri, vt[k].rq);
      tick();
      chk_out($sformatf("vec%0d hold", k), 4'h0, vt[k].ei, vt[k].eq, vt[k].ri, vt[k].rq);
    end
    chk_uf("table_no_uf", 1'b0, 16'd0);

    // Full / backpressure
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_axis_tdata = vt[k].data;
      tick();
    end
    chk_lvl("full", 3'd4, 1'b0);
    s_axis_tdata = vt[0].data;
    sample_req   = 1'b1;
    tick();
    sample_req = 1'b0;
    chk_lvl("full_pop", 3'd3, 1'b1);
    chk_out("full_pop", 4'hF, vt[0].ei, vt[0].eq, vt[0].ri, vt[0].rq);
    tick();
    s_axis_tvalid = 1'b0;
    chk_lvl("fifth_push", 3'd4, 1'b0);
    sample_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_out($sformatf("drain%0d", k), 4'hF, vt[k%4].ei, vt[k%4].eq, vt[k%4].ri, vt[k%4].rq);
    end

    // Underflow: three requests on empty FIFO
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("uf%0d", k), 4'hF, '0, '0, vt[0].ri, vt[0].rq);
    end
    chk_uf("uf_x3", 1'b1, 16'd3);
    chk_lvl("uf_x3", 3'd0, 1'b1);
    underflow_clear = 1'b1;
    tick();
    chk_uf("clear_vs_event", 1'b1, 16'd1);
    sample_req = 1'b0;
    tick();
    underflow_clear = 1'b0;
    chk_uf("clear_only", 1'b0, 16'd0);

    // Push then request in the same cycle on empty FIFO: no fall-through
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = vt[1].data;
    sample_req    = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    sample_req    = 1'b0;
    chk_uf("no_fallthrough", 1'b1, 16'd1);
    chk_out("no_fallthrough", 4'hF, '0, '0, vt[0].ri, vt[0].rq);
    chk_lvl("no_fallthrough", 3'd1, 1'b1);

    // Enable gating
    push(vt[2].data);
    chk_lvl("queued2", 3'd2, 1'b1);
    tx_enable = 1'b0;
    tick();
    chk_lvl("disabled", 3'd0, 1'b0);
    chk_out("disabled", 4'h0, '0, '0, '0, '0);
    sample_req = 1'b1;
    tick();
    chk_out("disabled_req", 4'h0, '0, '0, '0, '0);
    chk_uf("disabled_req", 1'b1, 16'd1);
    tx_enable = 1'b1;
    tick();
    sample_req = 1'b0;
    chk_out("reenable_uf", 4'hF, '0, '0, '0, '0);
    chk_uf("reenable_uf", 1'b1, 16'd2);

    // Saturation
    underflow_clear = 1'b1;
    tick();
    underflow_clear = 1'b0;
    chk_uf("sat_clear", 1'b0, 16'd0);
    sample_req = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    chk_uf("sat_reach", 1'b1, 16'hFFFF);
    tick();
    sample_req = 1'b0;
    chk_uf("sat_hold", 1'b1, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
